// File: rtl/video_hdmiport.sv
// Output stage from the MDA/CGA pixel pipeline to an external HDMI encoder.
// It registers the pixel stream, maps it to RGBI pins, divides the clock and applies a programmable DE delay.
module video_hdmiport #(
    parameter int CLK_DIV  = 2,
    parameter int DE_DELAY = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cga_mode,
    input  logic       i_video,
    input  logic       i_intensity,
    input  logic [3:0] i_rgbi,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_display_enable,
    input  logic       i_switch2,
    input  logic       i_switch3,
    output logic       o_hdmi_red,
    output logic       o_hdmi_grn,
    output logic       o_hdmi_blu,
    output logic       o_hdmi_int,
    output logic       o_hdmi_grn_int,
    output logic       o_hdmi_hs,
    output logic       o_hdmi_vs,
    output logic       o_hdmi_de,
    output logic       o_hdmi_clk
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam int            DW   = DE_DELAY + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_video;
    logic          r_intensity;
    logic [3:0]    r_rgbi;
    logic          r_hs;
    logic          r_vs;
    logic          r_vs_prev;
    logic [DW-1:0] r_de_pipe;
    logic [1:0]    r_sw_meta;
    logic [1:0]    r_sw_sync;
    logic [1:0]    r_sel;
    logic          w_strobe;
    logic          w_vs_rise;
    logic [4:0]    w_colour;

    assign w_strobe  = (r_div_cnt == LAST);
    assign w_vs_rise = r_vs & ~r_vs_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt  <= '0;
            o_hdmi_clk <= 1'b0;
        end else if (w_strobe) begin
            r_div_cnt  <= '0;
            o_hdmi_clk <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
            if (r_div_cnt == HALF) begin
                o_hdmi_clk <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_video     <= 1'b0;
            r_intensity <= 1'b0;
            r_rgbi      <= 4'b0000;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_de_pipe   <= '0;
            r_sw_meta   <= 2'b00;
            r_sw_sync   <= 2'b00;
            r_sel       <= 2'b00;
        end else begin
            r_video     <= i_video;
            r_intensity <= i_intensity;
            r_rgbi      <= i_rgbi;
            r_hs        <= i_hsync;
            r_vs        <= i_vsync;
            r_vs_prev   <= r_vs;
            r_de_pipe   <= DW'({r_de_pipe, i_display_enable});
            r_sw_meta   <= {i_switch2, i_switch3};
            r_sw_sync   <= r_sw_meta;
            // Colour choice only changes at a frame start so a frame is never drawn in two colours
            if (w_vs_rise) begin
                r_sel <= r_sw_sync;
            end
        end
    end

    always_comb begin
        w_colour = 5'b00000;
        if (i_cga_mode) begin
            if (r_rgbi == 4'b0110) begin
                w_colour = 5'b10001;
            end else begin
                w_colour = {r_rgbi, r_rgbi[0]};
            end
        end else begin
            case (r_sel)
                2'b00:   w_colour[4:2] = {1'b0, r_video, 1'b0};
                2'b01:   w_colour[4:2] = {r_video, r_video, 1'b0};
                2'b10:   w_colour[4:2] = {r_video, r_video, r_video};
                default: w_colour[4:2] = {r_video, 2'b00};
            endcase
            w_colour[1:0] = {2{r_intensity & r_video}};
        end
        if (!r_de_pipe[DE_DELAY]) begin
            w_colour = 5'b00000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            {o_hdmi_red, o_hdmi_grn, o_hdmi_blu, o_hdmi_int, o_hdmi_grn_int} <= 5'b00000;
            o_hdmi_hs <= HS_POL;
            o_hdmi_vs <= VS_POL;
            o_hdmi_de <= 1'b0;
        end else if (w_strobe) begin
            {o_hdmi_red, o_hdmi_grn, o_hdmi_blu, o_hdmi_int, o_hdmi_grn_int} <= w_colour;
            o_hdmi_hs <= r_hs ^ HS_POL;
            o_hdmi_vs <= r_vs ^ VS_POL;
            o_hdmi_de <= r_de_pipe[DE_DELAY];
        end
    end

endmodule

// File: tb/tb_video_hdmiport.sv
// Bench for video_hdmiport: three parameter sets driven by one shared input stream.
// Expected outputs come from an input-history model of the pixel, DE and switch timing rules.
module tb_video_hdmiport;

    localparam int NI   = 3;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       reset, cgaMode, video, intensity, hsync, vsync, de, sw2, sw3;
    logic [3:0] rgbi;
    logic [7:0] obsOut [NI];
    logic       obsClk [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int P_CD = (g == 0) ? 2 : ((g == 1) ? 4 : 6);
        localparam int P_DD = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        localparam bit P_HP = (g == 1);
        localparam bit P_VP = (g != 0);
        logic red, grn, blu, hdmiInt, gint, hs, vs, hde, hclk;
        video_hdmiport #(.CLK_DIV(P_CD), .DE_DELAY(P_DD), .HS_POL(P_HP), .VS_POL(P_VP)) u_dut (
            .i_clk(clk), .i_reset(reset), .i_cga_mode(cgaMode), .i_video(video),
            .i_intensity(intensity), .i_rgbi(rgbi), .i_hsync(hsync), .i_vsync(vsync),
            .i_display_enable(de), .i_switch2(sw2), .i_switch3(sw3),
            .o_hdmi_red(red), .o_hdmi_grn(grn), .o_hdmi_blu(blu), .o_hdmi_int(hdmiInt),
            .o_hdmi_grn_int(gint), .o_hdmi_hs(hs), .o_hdmi_vs(vs), .o_hdmi_de(hde),
            .o_hdmi_clk(hclk)
        );
        assign obsOut[g] = {red, grn, blu, hdmiInt, gint, hs, vs, hde};
        assign obsClk[g] = hclk;
    end

    // Per-edge input history: {video, intensity, rgbi[3:0], hsync, vsync, de} and {switch2, switch3}
    logic [8:0] rawIn [MAXE];
    logic [1:0] swIn  [MAXE];
    logic [2:0] mdaTint [4] = '{3'b010, 3'b110, 3'b111, 3'b100};
    logic [7:0] expOut [NI];
    logic [1:0] selM;
    int         edgeNum   = 0;
    int         lastRst   = 0;
    int         testCount = 0;
    int         failCount = 0;

    function automatic int cdOf(int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 6);
    endfunction
    function automatic int delayOf(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction
    function automatic logic hpOf(int k);
        return (k == 1);
    endfunction
    function automatic logic vpOf(int k);
        return (k != 0);
    endfunction
    function automatic logic [7:0] resetVal(int k);
        return {5'b00000, hpOf(k), vpOf(k), 1'b0};
    endfunction

    function automatic logic [8:0] rawAt(int idx);
        if (idx <= lastRst) return 9'd0;
        return rawIn[idx];
    endfunction
    function automatic logic [1:0] swAt(int idx);
        if (idx <= lastRst) return 2'b00;
        return swIn[idx];
    endfunction

    function automatic logic [7:0] modelOut(int k, logic [1:0] sel);
        logic [8:0] s;
        logic [8:0] d;
        logic [3:0] q;
        logic [4:0] c;
        s = rawAt(edgeNum - 1);
        d = rawAt(edgeNum - 1 - delayOf(k));
        q = s[6:3];
        if (cgaMode) c = (q == 4'b0110) ? 5'b10001 : {q, q[0]};
        else         c = {s[8] ? mdaTint[sel] : 3'b000, {2{s[8] & s[7]}}};
        if (!d[0]) c = 5'b00000;
        return {c, s[2] ^ hpOf(k), s[1] ^ vpOf(k), d[0]};
    endfunction

    task automatic tick();
        logic [8:0] v1;
        logic [8:0] v2;
        logic       expClk;
        int         n;
        @(posedge clk);
        edgeNum++;
        rawIn[edgeNum] = {video, intensity, rgbi, hsync, vsync, de};
        swIn[edgeNum]  = {sw2, sw3};
        if (reset) begin
            lastRst = edgeNum;
            selM    = 2'b00;
            for (int k = 0; k < NI; k++) expOut[k] = resetVal(k);
        end else begin
            n = edgeNum - lastRst;
            for (int k = 0; k < NI; k++) begin
                if (n % cdOf(k) == 0) expOut[k] = modelOut(k, selM);
            end
            v1 = rawAt(edgeNum - 1);
            v2 = rawAt(edgeNum - 2);
            if (v1[1] && !v2[1]) selM = swAt(edgeNum - 2);
        end
        n = edgeNum - lastRst;
        #1;
        for (int k = 0; k < NI; k++) begin
            expClk = ((n % cdOf(k)) >= (cdOf(k) / 2));
            testCount++;
            assert (obsOut[k] === expOut[k]) else begin
                failCount++;
                $error("[TB] FAIL out%0d edge %0d: observed %b expected %b", k, edgeNum, obsOut[k], expOut[k]);
            end
            testCount++;
            assert (obsClk[k] === expClk) else begin
                failCount++;
                $error("[TB] FAIL clk%0d edge %0d: observed %b expected %b", k, edgeNum, obsClk[k], expClk);
            end
        end
    endtask

    task automatic ticks(int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic checkReset(string tag);
        for (int k = 0; k < NI; k++) begin
            testCount++;
            assert (obsOut[k] === resetVal(k) && obsClk[k] === 1'b0) else begin
                failCount++;
                $error("[TB] FAIL %s inst%0d: observed %b/%b expected %b/0", tag, k, obsOut[k], obsClk[k], resetVal(k));
            end
        end
    endtask

    task automatic checkColour(string tag, logic [4:0] want);
        for (int k = 0; k < NI; k++) begin
            testCount++;
            assert (obsOut[k][7:3] === want) else begin
                failCount++;
                $error("[TB] FAIL %s inst%0d: observed %b expected %b", tag, k, obsOut[k][7:3], want);
            end
        end
    endtask

    task automatic randomCycles(int cnt);
        for (int i = 0; i < cnt; i++) begin
            video     = 1'($urandom);
            intensity = 1'($urandom);
            rgbi      = 4'($urandom);
            hsync     = 1'($urandom);
            de        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) vsync = ~vsync;
            if ($urandom_range(0, 7) == 0) {sw2, sw3} = 2'($urandom);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; cgaMode = 1'b0; video = 1'b0; intensity = 1'b0; rgbi = 4'b0000;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0; sw2 = 1'b0; sw3 = 1'b0;
        ticks(3);
        checkReset("reset_hold");
        reset = 1'b0;
        tick();
        testCount++;
        assert (obsClk[0] === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL first_rise: observed %b expected 1", obsClk[0]);
        end

        // MDA colour selection, then a mid-frame switch change that must stay invisible
        de = 1'b1; video = 1'b1;
        for (int s = 0; s < 4; s++) begin
            {sw2, sw3} = 2'(s);
            vsync = 1'b0; ticks(3);
            vsync = 1'b1; ticks(4);
            vsync = 1'b0; ticks(24);
            checkColour("mda_sel", {mdaTint[s], 2'b00});
            {sw2, sw3} = ~2'(s);
            ticks(20);
            checkColour("mda_midframe", {mdaTint[s], 2'b00});
        end

        randomCycles(300);

        reset = 1'b1;
        tick();
        checkReset("reset_midline");
        cgaMode = 1'b1;
        reset   = 1'b0;

        de = 1'b1; hsync = 1'b0; vsync = 1'b0; rgbi = 4'b0110;
        ticks(30);
        checkColour("cga_brown", 5'b10001);
        rgbi = 4'b1111;
        ticks(30);
        checkColour("cga_white", 5'b11111);

        randomCycles(300);

        reset = 1'b1;
        ticks(2);
        checkReset("reset_cga");
        cgaMode = 1'b0;
        reset   = 1'b0;
        randomCycles(300);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
